// File: rtl/obstacle_scroller_if.sv
// Bundles the game-FSM inputs, glyph ROM input and display/status outputs of obstacle_scroller.
interface obstacle_scroller_if #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned SEG_W  = 7
);
  logic [2:0]              presente;
  logic [1:0]              W_or_L;
  logic [SEG_W-1:0]        obstaculo;
  logic                    tick;
  logic [3:0]              tipo_obs;
  logic [DIGITS*SEG_W-1:0] display_obs;
  logic [7:0]              pass_cnt;
  logic [3:0]              speed_level;
  logic [1:0]              state_o;

  modport master (
    output presente, W_or_L, obstaculo,
    input  tick, tipo_obs, display_obs, pass_cnt, speed_level, state_o
  );

  modport slave (
    input  presente, W_or_L, obstaculo,
    output tick, tipo_obs, display_obs, pass_cnt, speed_level, state_o
  );
endinterface

// File: rtl/obstacle_scroller.sv
// Game-tick divider, LFSR obstacle picker and DIGITS-wide glyph scroller with gap rule.
// Define OBSTACLE_SPEEDUP_EN to shorten the tick period as obstacles are passed.
//
// state | meaning
// IDLE  | display and counters cleared, waiting for presente==GAME with W_or_L==00
// SEED  | one tick that loads the LFSR from the free-running seed counter
// RUN   | each tick: scroll, maybe spawn, step LFSR, count passes
// HOLD  | win/lose freeze; leaves only to IDLE
module obstacle_scroller #(
  parameter int unsigned        DIGITS        = 3,
  parameter int unsigned        SEG_W         = 7,
  parameter int unsigned        LFSR_W        = 8,
  parameter logic [LFSR_W-1:0]  TAPS          = LFSR_W'(8'h71),
  parameter int unsigned        DIV_INIT      = 13500000,
  parameter int unsigned        DIV_MIN       = 3375000,
  parameter int unsigned        DIV_STEP      = 1350000,
  parameter int unsigned        GAP_MIN       = 1,
  parameter int unsigned        GAP_MAX       = 4,
  parameter int unsigned        SPEEDUP_EVERY = 8
) (
  input  logic               clk,
  input  logic               rst,
  obstacle_scroller_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEED = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam int unsigned        GAP_W     = $clog2(GAP_MAX + 1);
  localparam logic [GAP_W-1:0]   GAP_MIN_V = GAP_W'(GAP_MIN);
  localparam logic [GAP_W-1:0]   GAP_MAX_V = GAP_W'(GAP_MAX);
  localparam logic [2:0]         GAME      = 3'd3;
  localparam int unsigned        DISP_W    = DIGITS * SEG_W;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_div_cnt;
  logic [31:0]         w_div_val;
  logic                w_tick;
  logic [LFSR_W-1:0]   r_seed;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [DISP_W-1:0]   r_disp;
  logic [GAP_W-1:0]    r_gap;
  logic [7:0]          r_pass;
  logic                w_clear;
  logic                w_load;
  logic                w_scroll;
  logic                w_spawn;
  logic                w_pass_inc;
  logic                w_abort;
  logic                w_pause;
  logic                w_go;
  logic [SEG_W-1:0]    w_top;

  // The >= compare lets a shrinking divisor take effect without waiting for a 32-bit wrap.
  assign w_tick = (r_div_cnt >= (w_div_val - 32'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= 32'd0;
    end else if (w_tick) begin
      r_div_cnt <= 32'd0;
    end else begin
      r_div_cnt <= r_div_cnt + 32'd1;
    end
  end

  assign w_abort = (bus.W_or_L == 2'b11);
  assign w_pause = (bus.W_or_L == 2'b01) || (bus.W_or_L == 2'b10);
  assign w_go    = (bus.presente == GAME) && (bus.W_or_L == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_load      = 1'b0;
    w_scroll    = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          w_clear = 1'b1;
          if (w_go) begin
            w_state_nxt = S_SEED;
          end
        end
        S_SEED: begin
          if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_clear     = 1'b1;
          end else if (w_pause) begin
            w_state_nxt = S_HOLD;
          end else if (bus.presente != GAME) begin
            w_state_nxt = S_IDLE;
            w_clear     = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
            w_load      = 1'b1;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_clear     = 1'b1;
          end else if (w_pause) begin
            w_state_nxt = S_HOLD;
          end else if (bus.presente != GAME) begin
            w_state_nxt = S_IDLE;
            w_clear     = 1'b1;
          end else begin
            w_scroll = 1'b1;
          end
        end
        S_HOLD: begin
          if (!w_pause) begin
            w_state_nxt = S_IDLE;
            w_clear     = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end
      endcase
    end
  end

  // Seed never holds 0 so a loaded LFSR can never lock up.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seed <= LFSR_W'(1);
    end else if (r_state == S_IDLE) begin
      r_seed <= (r_seed == '1) ? LFSR_W'(1) : r_seed + LFSR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_W'(1);
    end else if (w_load) begin
      r_lfsr <= r_seed;
    end else if (w_scroll) begin
      r_lfsr <= {^(r_lfsr & TAPS), r_lfsr[LFSR_W-1:1]};
    end
  end

  assign w_spawn    = ((r_gap >= GAP_MIN_V) && r_lfsr[0]) || (r_gap == GAP_MAX_V);
  assign w_top      = w_spawn ? bus.obstaculo : '0;
  assign w_pass_inc = w_scroll && (r_disp[SEG_W-1:0] != '0) && (r_pass != 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp <= '0;
      r_gap  <= '0;
      r_pass <= 8'd0;
    end else if (w_clear) begin
      r_disp <= '0;
      r_gap  <= '0;
      r_pass <= 8'd0;
    end else if (w_scroll) begin
      r_disp <= {w_top, r_disp[DISP_W-1:SEG_W]};
      r_gap  <= w_spawn ? '0 : r_gap + GAP_W'(1);
      if (w_pass_inc) begin
        r_pass <= r_pass + 8'd1;
      end
    end
  end

`ifdef OBSTACLE_SPEEDUP_EN
  localparam logic [7:0] SPD_LAST = 8'(SPEEDUP_EVERY - 1);

  logic [31:0] r_div_val;
  logic [7:0]  r_spd_cnt;
  logic [3:0]  r_level;
  logic        w_level_up;

  // r_spd_cnt tracks pass_cnt modulo SPEEDUP_EVERY without a divider.
  assign w_level_up = w_pass_inc && (r_spd_cnt == SPD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_val <= 32'(DIV_INIT);
      r_spd_cnt <= 8'd0;
      r_level   <= 4'd0;
    end else if (w_clear) begin
      r_div_val <= 32'(DIV_INIT);
      r_spd_cnt <= 8'd0;
      r_level   <= 4'd0;
    end else if (w_pass_inc) begin
      r_spd_cnt <= w_level_up ? 8'd0 : r_spd_cnt + 8'd1;
      if (w_level_up) begin
        r_level   <= (r_level == 4'hF) ? 4'hF : r_level + 4'd1;
        r_div_val <= (r_div_val >= 32'(DIV_MIN + DIV_STEP)) ?
                     r_div_val - 32'(DIV_STEP) : 32'(DIV_MIN);
      end
    end
  end

  assign w_div_val       = r_div_val;
  assign bus.speed_level = r_level;
`else
  logic w_unused_cfg;

  assign w_div_val       = 32'(DIV_INIT);
  assign bus.speed_level = 4'd0;
  assign w_unused_cfg    = ^{32'(DIV_MIN), 32'(DIV_STEP), 32'(SPEEDUP_EVERY)};
`endif

  assign bus.tick        = w_tick;
  assign bus.tipo_obs    = r_lfsr[3:0];
  assign bus.display_obs = r_disp;
  assign bus.pass_cnt    = r_pass;
  assign bus.state_o     = r_state;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench for obstacle_scroller: table vectors for the first RUN ticks, a spec model for long runs.
module tb_obstacle_scroller;

  typedef struct packed {
    logic [7:0]  lfsr;
    logic [2:0]  gap;
    logic [20:0] disp;
    logic [7:0]  pass;
  } model_t;

  typedef struct {
    logic [6:0]  obs;
    logic [20:0] disp;
    logic [7:0]  pass;
    logic [3:0]  tipo;
  } vec_t;

  logic clk;
  logic rst;
  logic rst_s;
  int   n_vec;
  int   n_err;
  model_t m;
  int   blank_run;
  int   run_ticks;

  obstacle_scroller_if #(.DIGITS(3), .SEG_W(7)) bus_m ();
  obstacle_scroller_if #(.DIGITS(3), .SEG_W(7)) bus_s ();

  obstacle_scroller #(
    .DIV_INIT(4), .DIV_MIN(4), .DIV_STEP(1)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus_m)
  );

  obstacle_scroller #(
    .DIV_INIT(40), .DIV_MIN(20), .DIV_STEP(10), .SPEEDUP_EVERY(2)
  ) u_spd (
    .clk(clk), .rst(rst_s), .bus(bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic model_t step(input model_t cur, input logic [6:0] obs);
    model_t nx;
    logic   spawn;
    nx    = cur;
    spawn = ((cur.gap >= 3'd1) && cur.lfsr[0]) || (cur.gap == 3'd4);
    if ((cur.disp[6:0] != 7'd0) && (cur.pass != 8'hFF)) nx.pass = cur.pass + 8'd1;
    nx.disp = {(spawn ? obs : 7'd0), cur.disp[20:7]};
    nx.gap  = spawn ? 3'd0 : cur.gap + 3'd1;
    nx.lfsr = {^(cur.lfsr & 8'h71), cur.lfsr[7:1]};
    return nx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_tick(input bit sel, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sel ? bus_s.tick : bus_m.tick) && n < 200);
    if (!(sel ? bus_s.tick : bus_m.tick)) begin
      n_vec++;
      n_err++;
      $display("FAIL tick_timeout: got no tick in %0d cycles, expected one", n);
    end
  endtask

  task automatic do_reset(input bit sel);
    if (sel) rst_s = 1'b1; else rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (sel) rst_s = 1'b0; else rst = 1'b0;
  endtask

  // Positioned at a tick's negedge: apply obstaculo, take the tick, compare to the model.
  task automatic run_tick(input logic [6:0] obs);
    int n;
    bus_m.obstaculo = obs;
    @(posedge clk);
    #1;
    m = step(m, obs);
    chk("run_disp", 32'(bus_m.display_obs), 32'(m.disp));
    chk("run_pass", 32'(bus_m.pass_cnt), 32'(m.pass));
    chk("run_tipo", 32'(bus_m.tipo_obs), 32'(m.lfsr[3:0]));
    chk("adjacent", 32'(((bus_m.display_obs[6:0] != 0) && (bus_m.display_obs[13:7] != 0)) ||
                        ((bus_m.display_obs[13:7] != 0) && (bus_m.display_obs[20:14] != 0))), 32'd0);
    if (bus_m.display_obs[20:14] == 7'd0) blank_run++; else blank_run = 0;
    chk("blank_run", 32'(blank_run > 4), 32'd0);
    run_ticks++;
    next_tick(1'b0, n);
  endtask

  initial begin
    vec_t   vt[8];
    model_t ms;
    model_t held;
    int     n;
    int     guard;
    int     exp_div;
    int     exp_lvl;
    logic [7:0] old_pass;

    vt[0] = '{7'h7F, 21'd0,                    8'd0, 4'h2};
    vt[1] = '{7'h7F, 21'd0,                    8'd0, 4'h1};
    vt[2] = '{7'h3F, {7'h3F, 7'h00, 7'h00},    8'd0, 4'h0};
    vt[3] = '{7'h7F, {7'h00, 7'h3F, 7'h00},    8'd0, 4'h0};
    vt[4] = '{7'h7F, {7'h00, 7'h00, 7'h3F},    8'd0, 4'h8};
    vt[5] = '{7'h7F, 21'd0,                    8'd1, 4'h4};
    vt[6] = '{7'h7F, 21'd0,                    8'd1, 4'h2};
    vt[7] = '{7'h06, {7'h06, 7'h00, 7'h00},    8'd1, 4'h9};

    n_vec = 0;
    n_err = 0;
    blank_run = 0;
    run_ticks = 0;
    rst = 1'b1;
    rst_s = 1'b1;
    bus_m.presente = 3'd3;
    bus_m.W_or_L = 2'b00;
    bus_m.obstaculo = 7'h7F;
    bus_s.presente = 3'd3;
    bus_s.W_or_L = 2'b00;
    bus_s.obstaculo = 7'h7F;

    // Reset, divider cadence and IDLE -> SEED -> RUN with seed 5.
    do_reset(1'b0);
    chk("rst_pass", 32'(bus_m.pass_cnt), 32'd0);
    chk("rst_speed", 32'(bus_m.speed_level), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      if (i > 1) @(negedge clk);
      chk("tick_cadence", 32'(bus_m.tick), 32'(i % 4 == 0));
      chk("start_state", 32'(bus_m.state_o), (i <= 4) ? 32'd0 : (i <= 8) ? 32'd1 : 32'd2);
      chk("start_tipo", 32'(bus_m.tipo_obs), (i <= 8) ? 32'd1 : 32'd5);
      chk("start_disp", 32'(bus_m.display_obs), 32'd0);
    end

    for (int k = 0; k < 8; k++) begin
      bus_m.obstaculo = vt[k].obs;
      @(posedge clk);
      #1;
      chk("vec_disp", 32'(bus_m.display_obs), 32'(vt[k].disp));
      chk("vec_pass", 32'(bus_m.pass_cnt), 32'(vt[k].pass));
      chk("vec_tipo", 32'(bus_m.tipo_obs), 32'(vt[k].tipo));
      chk("vec_state", 32'(bus_m.state_o), 32'd2);
      next_tick(1'b0, n);
    end

    // Model-checked run up to 20 passes, then a win/lose hold.
    m = '{lfsr: 8'hB9, gap: 3'd0, disp: {7'h06, 14'd0}, pass: 8'd1};
    guard = 0;
    while (m.pass < 8'd20 && guard < 400) begin
      run_tick((run_ticks < 20) ? 7'h7F : 7'($urandom_range(1, 127)));
      guard++;
    end
    chk("reach_20", 32'(m.pass >= 8'd20), 32'd1);

    held = m;
    bus_m.W_or_L = 2'b10;
    bus_m.presente = 3'd0;
    @(posedge clk);
    #1;
    chk("hold_enter", 32'(bus_m.state_o), 32'd3);
    for (int k = 0; k < 10; k++) begin
      next_tick(1'b0, n);
      bus_m.obstaculo = 7'h7F;
      @(posedge clk);
      #1;
      chk("hold_state", 32'(bus_m.state_o), 32'd3);
      chk("hold_disp", 32'(bus_m.display_obs), 32'(held.disp));
      chk("hold_pass", 32'(bus_m.pass_cnt), 32'(held.pass));
      chk("hold_tipo", 32'(bus_m.tipo_obs), 32'(held.lfsr[3:0]));
    end
    next_tick(1'b0, n);
    bus_m.W_or_L = 2'b00;
    @(posedge clk);
    #1;
    chk("hold_exit_state", 32'(bus_m.state_o), 32'd0);
    chk("hold_exit_disp", 32'(bus_m.display_obs), 32'd0);
    chk("hold_exit_pass", 32'(bus_m.pass_cnt), 32'd0);

    // Fresh game from the same seed, run until pass_cnt saturates.
    bus_m.presente = 3'd3;
    do_reset(1'b0);
    next_tick(1'b0, n);
    @(posedge clk);
    next_tick(1'b0, n);
    @(posedge clk);
    next_tick(1'b0, n);
    m = '{lfsr: 8'h05, gap: 3'd0, disp: 21'd0, pass: 8'd0};
    blank_run = 0;
    guard = 0;
    while (guard < 2000) begin
      run_tick(7'($urandom_range(1, 127)));
      guard++;
      if (m.pass == 8'hFF && guard > 900) break;
    end
    chk("pass_sat", 32'(bus_m.pass_cnt), 32'd255);

    // Abort from RUN wins over a valid GAME state.
    bus_m.W_or_L = 2'b11;
    @(posedge clk);
    #1;
    chk("abort_state", 32'(bus_m.state_o), 32'd0);
    chk("abort_disp", 32'(bus_m.display_obs), 32'd0);
    chk("abort_pass", 32'(bus_m.pass_cnt), 32'd0);

    // Seed counter wraps 255 -> 1: 260 IDLE clocks leave it at 6.
    bus_m.W_or_L = 2'b00;
    bus_m.presente = 3'd0;
    do_reset(1'b0);
    repeat (257) @(negedge clk);
    bus_m.presente = 3'd3;
    next_tick(1'b0, n);
    @(posedge clk);
    #1;
    chk("wrap_seed_state", 32'(bus_m.state_o), 32'd1);
    next_tick(1'b0, n);
    @(posedge clk);
    #1;
    chk("wrap_run_state", 32'(bus_m.state_o), 32'd2);
    chk("wrap_tipo", 32'(bus_m.tipo_obs), 32'd6);

    // Speed-up instance: divisor 40 -> 30 -> 20 every 2 passes (feature builds only).
    do_reset(1'b1);
    next_tick(1'b1, n);
    @(posedge clk);
    #1;
    chk("spd_seed_state", 32'(bus_s.state_o), 32'd1);
    next_tick(1'b1, n);
    chk("spd_idle_period", 32'(n), 32'd40);
    @(posedge clk);
    #1;
    chk("spd_run_state", 32'(bus_s.state_o), 32'd2);
    chk("spd_tipo", 32'(bus_s.tipo_obs), 32'd9);
    ms = '{lfsr: 8'h29, gap: 3'd0, disp: 21'd0, pass: 8'd0};
    exp_div = 40;
    exp_lvl = 0;
    for (int k = 0; k < 40; k++) begin
      next_tick(1'b1, n);
      chk("spd_period", 32'(n), 32'(exp_div));
      bus_s.obstaculo = 7'h7F;
      @(posedge clk);
      #1;
      old_pass = ms.pass;
      ms = step(ms, 7'h7F);
`ifdef OBSTACLE_SPEEDUP_EN
      if (ms.pass != old_pass && ms.pass % 2 == 0) begin
        exp_div = (exp_div >= 30) ? exp_div - 10 : 20;
        if (exp_lvl < 15) exp_lvl++;
      end
`endif
      chk("spd_pass", 32'(bus_s.pass_cnt), 32'(ms.pass));
      chk("spd_level", 32'(bus_s.speed_level), 32'(exp_lvl));
    end
    chk("spd_passes_seen", 32'(ms.pass >= 8'd6), 32'd1);

    do_reset(1'b1);
    next_tick(1'b1, n);
    chk("spd_rst_first", 32'(n), 32'd39);
    @(posedge clk);
    next_tick(1'b1, n);
    chk("spd_rst_period", 32'(n), 32'd40);
    chk("spd_rst_level", 32'(bus_s.speed_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
